// File: rtl/clkgate_idle_ctrl_if.sv
// ---------------------------------------------------------------------------
// clkgate_idle_ctrl_if
// Bundles the activity, override, threshold, wake handshake and gate-enable
// signals of the idle-detect clock-gate controller.
//   master : the gated domain / software side (drives activity and requests)
//   slave  : the controller (drives E, GATED, WAKE_ACK and statistics)
// Optional feature macro: CLKGATE_STAT_EN adds GATED_CNT and parameter CNTW.
// ---------------------------------------------------------------------------
interface clkgate_idle_ctrl_if #(
  parameter int CW = 8
`ifdef CLKGATE_STAT_EN
  ,
  parameter int CNTW = 16
`endif
);

  logic            BUSY;
  logic            FORCE_ON;
  logic [CW-1:0]   IDLE_THRESH;
  logic            WAKE_REQ;
  logic            WAKE_ACK;
  logic            E;
  logic            GATED;
`ifdef CLKGATE_STAT_EN
  logic [CNTW-1:0] GATED_CNT;
`endif

  // Requester / gated-domain side
  modport master (
    output BUSY,
    output FORCE_ON,
    output IDLE_THRESH,
    output WAKE_REQ,
    input  WAKE_ACK,
    input  E,
    input  GATED
`ifdef CLKGATE_STAT_EN
    ,
    input  GATED_CNT
`endif
  );

  // Controller side
  modport slave (
    input  BUSY,
    input  FORCE_ON,
    input  IDLE_THRESH,
    input  WAKE_REQ,
    output WAKE_ACK,
    output E,
    output GATED
`ifdef CLKGATE_STAT_EN
    ,
    output GATED_CNT
`endif
  );

endinterface

// File: rtl/clkgate_idle_ctrl.sv
// ---------------------------------------------------------------------------
// clkgate_idle_ctrl
// Idle-detect controller driving the E pin of an integrated clock gate.
// Counts consecutive idle cycles of the gated domain and drops E once the
// programmable threshold is reached; raises E again on activity, software
// override or a four-phase wake request, and acknowledges the request once
// the gated clock has been running for WAKE_CYC cycles.
// Runs on the free-running clock that also feeds the ICG CLK pin.
// Optional feature macro: CLKGATE_STAT_EN (saturating gated-cycle counter
// GATED_CNT of width CNTW).
// ---------------------------------------------------------------------------
module clkgate_idle_ctrl #(
  parameter int CW       = 8,
  parameter int WAKE_CYC = 2
`ifdef CLKGATE_STAT_EN
  ,
  parameter int CNTW     = 16
`endif
) (
  input  logic                CLK,
  input  logic                RN,
  clkgate_idle_ctrl_if.slave  bus
);

  // ON    : clock running, no idle streak in progress
  // COUNT : clock running, idle streak being counted
  // OFF   : clock gated
  // WAKE  : clock re-enabled, waiting for it to settle before returning to ON
  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_COUNT = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  // Wake counter only has to reach WAKE_CYC-1.
  localparam int            WW        = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] IDLE_MAX  = {CW{1'b1}};

  // Saturating increment for the idle counter.
  function automatic logic [CW-1:0] idle_sat_inc(input logic [CW-1:0] val);
    logic [CW-1:0] res;
    if (val == IDLE_MAX) begin
      res = IDLE_MAX;
    end else begin
      res = val + CW'(1'b1);
    end
    return res;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_idle_cnt;
  logic [CW-1:0] w_idle_cnt_nxt;
  logic [WW-1:0] r_wake_cnt;
  logic [WW-1:0] w_wake_cnt_nxt;

  logic          r_e;
  logic          r_gated;
  logic          r_wake_ack;

  logic          w_idle;
  logic          w_wake;
  logic [CW-1:0] w_thresh_m1;
  logic          w_thresh_hit;

  // A zero threshold disables gating entirely, so it never counts as idle.
  assign w_idle = !bus.BUSY && !bus.FORCE_ON && !bus.WAKE_REQ &&
                  (bus.IDLE_THRESH != {CW{1'b0}});
  assign w_wake = bus.BUSY || bus.FORCE_ON || bus.WAKE_REQ;

  // Greater-or-equal so a threshold lowered mid-count gates on the next edge.
  // THRESH-1 only matters when THRESH!=0 (w_idle already excludes zero).
  assign w_thresh_m1  = bus.IDLE_THRESH - CW'(1'b1);
  assign w_thresh_hit = (r_idle_cnt >= w_thresh_m1);

  // Next-state and counter update logic for the gating FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    case (r_state)
      ST_ON: begin
        if (w_idle) begin
          w_state_nxt    = ST_COUNT;
          w_idle_cnt_nxt = {CW{1'b0}};
        end else begin
          w_state_nxt    = ST_ON;
        end
      end
      ST_COUNT: begin
        // Activity wins over threshold expiry in the same cycle.
        if (!w_idle) begin
          w_state_nxt    = ST_ON;
          w_idle_cnt_nxt = {CW{1'b0}};
        end else if (w_thresh_hit) begin
          w_state_nxt    = ST_OFF;
          w_idle_cnt_nxt = {CW{1'b0}};
        end else begin
          w_state_nxt    = ST_COUNT;
          w_idle_cnt_nxt = idle_sat_inc(r_idle_cnt);
        end
      end
      ST_OFF: begin
        if (w_wake) begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = {WW{1'b0}};
        end else begin
          w_state_nxt    = ST_OFF;
        end
      end
      ST_WAKE: begin
        // No path back to OFF: the wake sequence always completes.
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt    = ST_ON;
          w_wake_cnt_nxt = {WW{1'b0}};
        end else begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = r_wake_cnt + WW'(1'b1);
        end
      end
      default: begin
        w_state_nxt    = ST_ON;
        w_idle_cnt_nxt = {CW{1'b0}};
        w_wake_cnt_nxt = {WW{1'b0}};
      end
    endcase
  end

  // FSM state and counter registers; reset returns to ON.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state    <= ST_ON;
      r_idle_cnt <= {CW{1'b0}};
      r_wake_cnt <= {WW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
    end
  end

  // Output flops decoded from the state being entered, so E is glitch-free
  // and asynchronously forced high on reset (the ICG latches E while CLK low).
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_e        <= 1'b1;
      r_gated    <= 1'b0;
      r_wake_ack <= 1'b0;
    end else begin
      r_e        <= (w_state_nxt != ST_OFF);
      r_gated    <= (w_state_nxt == ST_OFF);
      r_wake_ack <= bus.WAKE_REQ && (w_state_nxt == ST_ON);
    end
  end

  assign bus.E        = r_e;
  assign bus.GATED    = r_gated;
  assign bus.WAKE_ACK = r_wake_ack;

`ifdef CLKGATE_STAT_EN
  localparam logic [CNTW-1:0] GCNT_MAX = {CNTW{1'b1}};

  logic [CNTW-1:0] r_gated_cnt;

  // Saturating count of edges spent in OFF; cleared only by reset.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_gated_cnt <= {CNTW{1'b0}};
    end else if ((r_state == ST_OFF) && (r_gated_cnt != GCNT_MAX)) begin
      r_gated_cnt <= r_gated_cnt + CNTW'(1'b1);
    end else begin
      r_gated_cnt <= r_gated_cnt;
    end
  end

  assign bus.GATED_CNT = r_gated_cnt;
`endif

endmodule

// File: tb/tb_clkgate_idle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clkgate_idle_ctrl
// Directed scenarios followed by constrained-random stimulus, checked every
// cycle against a behavioural model that tracks the idle run length and the
// remaining wake cycles.
// ---------------------------------------------------------------------------
module tb_clkgate_idle_ctrl;

  localparam int CW       = 8;
  localparam int WAKE_CYC = 2;
`ifdef CLKGATE_STAT_EN
  localparam int CNTW     = 4;
`endif

  logic CLK = 1'b0;
  logic RN;

  always #5 CLK = ~CLK;

`ifdef CLKGATE_STAT_EN
  clkgate_idle_ctrl_if #(.CW(CW), .CNTW(CNTW)) bus ();
  clkgate_idle_ctrl #(.CW(CW), .WAKE_CYC(WAKE_CYC), .CNTW(CNTW)) dut (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus)
  );
`else
  clkgate_idle_ctrl_if #(.CW(CW)) bus ();
  clkgate_idle_ctrl #(.CW(CW), .WAKE_CYC(WAKE_CYC)) dut (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus)
  );
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: gated flag, wake cycles still to run, idle run length.
  bit m_gated;
  int m_wake_left;
  int m_idle_run;
  bit m_ack;
`ifdef CLKGATE_STAT_EN
  int m_gcnt;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gated     = 1'b0;
    m_wake_left = 0;
    m_idle_run  = 0;
    m_ack       = 1'b0;
`ifdef CLKGATE_STAT_EN
    m_gcnt      = 0;
`endif
  endtask

  // One rising edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_edge();
    int thr;
    bit is_idle;
    bit is_wake;
    thr     = int'(bus.IDLE_THRESH);
    is_wake = bus.BUSY || bus.FORCE_ON || bus.WAKE_REQ;
    is_idle = !is_wake && (thr != 0);
`ifdef CLKGATE_STAT_EN
    if (m_gated && m_gcnt < (1 << CNTW) - 1) m_gcnt++;
`endif
    if (m_gated) begin
      if (is_wake) begin
        m_gated     = 1'b0;
        m_wake_left = WAKE_CYC;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
      m_idle_run = 0;
    end else if (!is_idle) begin
      m_idle_run = 0;
    end else if (m_idle_run >= 1 && m_idle_run >= thr) begin
      // The idle run counts the ON->COUNT edge; gating needs thr further idle edges.
      m_gated    = 1'b1;
      m_idle_run = 0;
    end else begin
      m_idle_run++;
    end
    m_ack = bus.WAKE_REQ && !m_gated && (m_wake_left == 0) && (m_idle_run == 0);
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".E"},     32'(bus.E),        32'(!m_gated));
    chk({ctx, ".GATED"}, 32'(bus.GATED),    32'(m_gated));
    chk({ctx, ".ACK"},   32'(bus.WAKE_ACK), 32'(m_ack));
`ifdef CLKGATE_STAT_EN
    chk({ctx, ".GCNT"},  32'(bus.GATED_CNT), 32'(m_gcnt));
`endif
  endtask

  // Advance one clock edge, update the model, sample 1 time unit later.
  task automatic step(input string ctx);
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs(ctx);
  endtask

  // Count edges until E reaches the given level (bounded).
  task automatic edges_until_e(input string ctx, input logic lvl, output int n);
    n = 0;
    do begin
      step(ctx);
      n++;
    end while (bus.E !== lvl && n < 40);
  endtask

  task automatic do_reset_release();
    @(posedge CLK);
    #1;
    RN = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    RN              = 1'b0;
    bus.BUSY        = 1'b1;
    bus.FORCE_ON    = 1'b0;
    bus.IDLE_THRESH = 8'd4;
    bus.WAKE_REQ    = 1'b0;
    model_reset();

    // 1: reset values, then busy keeps the clock running
    #12;
    chk("rst.E", 32'(bus.E), 32'd1);
    chk("rst.GATED", 32'(bus.GATED), 32'd0);
    chk("rst.ACK", 32'(bus.WAKE_ACK), 32'd0);
`ifdef CLKGATE_STAT_EN
    chk("rst.GCNT", 32'(bus.GATED_CNT), 32'd0);
`endif
    do_reset_release();
    for (int i = 0; i < 20; i++) step("busy_on");

    // 2: gate latency THRESH+1, wake on BUSY, gate again after WAKE + count
    bus.BUSY = 1'b0;
    edges_until_e("gate1", 1'b0, n);
    chk("gate1.latency", 32'(n), 32'd5);
    step("off_hold");
    bus.BUSY = 1'b1;
    step("busy_wake");
    chk("busy_wake.E", 32'(bus.E), 32'd1);
    bus.BUSY = 1'b0;
    edges_until_e("regate", 1'b0, n);
    chk("regate.latency", 32'(n), 32'd7);

    // 3: activity coincident with expiry restarts the full count
    bus.BUSY = 1'b1;
    step("wake3");
    for (int i = 0; i < 4; i++) step("wake3_run");
    bus.BUSY = 1'b0;
    for (int i = 0; i < 4; i++) step("pulse_cnt");
    bus.BUSY = 1'b1;
    step("pulse_hit");
    chk("pulse_hit.E", 32'(bus.E), 32'd1);
    bus.BUSY = 1'b0;
    edges_until_e("pulse_restart", 1'b0, n);
    chk("pulse_restart.latency", 32'(n), 32'd5);

    // 4: four-phase wake request from OFF
    bus.WAKE_REQ = 1'b1;
    n = 0;
    do begin
      step("req");
      n++;
      if (n == 1) chk("req.E_first_edge", 32'(bus.E), 32'd1);
    end while (bus.WAKE_ACK !== 1'b1 && n < 20);
    chk("req.ack_latency", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++) step("req_hold");
    bus.WAKE_REQ = 1'b0;
    step("req_drop");
    chk("req_drop.ACK", 32'(bus.WAKE_ACK), 32'd0);
    edges_until_e("req_regate", 1'b0, n);
    chk("req_regate.latency", 32'(n), 32'd4);

    // 5: THRESH=0 and FORCE_ON keep E high; async reset mid-COUNT and mid-OFF
    bus.BUSY = 1'b1;
    step("wake5");
    bus.BUSY = 1'b0;
    bus.IDLE_THRESH = 8'd0;
    for (int i = 0; i < 100; i++) step("thr0");
    chk("thr0.E", 32'(bus.E), 32'd1);
    bus.IDLE_THRESH = 8'd4;
    bus.FORCE_ON = 1'b1;
    for (int i = 0; i < 100; i++) step("force");
    chk("force.E", 32'(bus.E), 32'd1);
    bus.FORCE_ON = 1'b0;
    step("cnt5");
    step("cnt5");
    #2;
    RN = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_count");
    RN = 1'b1;
    edges_until_e("gate5", 1'b0, n);
    chk("gate5.latency", 32'(n), 32'd5);
    #2;
    RN = 1'b0;
    #1;
    chk("rst_off.E", 32'(bus.E), 32'd1);
    model_reset();
    check_outputs("rst_off");
    bus.BUSY = 1'b1;
    do_reset_release();
    step("after_rst");

    // 6: statistics counter saturation (only when the counter exists)
`ifdef CLKGATE_STAT_EN
    bus.BUSY = 1'b0;
    bus.IDLE_THRESH = 8'd1;
    for (int i = 0; i < 24; i++) step("stat");
    chk("stat.GCNT_sat", 32'(bus.GATED_CNT), 32'd15);
    bus.BUSY = 1'b1;
    for (int i = 0; i < 3; i++) step("stat_wake");
    chk("stat.GCNT_hold", 32'(bus.GATED_CNT), 32'd15);
`endif

    // Random phase: sparse activity, live threshold changes, legal wake handshakes
    bus.BUSY = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.BUSY     = ($urandom_range(0, 99) < 8);
      bus.FORCE_ON = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) bus.IDLE_THRESH = 8'($urandom_range(0, 6));
      if (!bus.WAKE_REQ && !m_ack && $urandom_range(0, 99) < 4) begin
        bus.WAKE_REQ = 1'b1;
      end else if (bus.WAKE_REQ && m_ack && $urandom_range(0, 99) < 40) begin
        bus.WAKE_REQ = 1'b0;
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
